intersection_model: RTL and testbench

Closed-loop traffic model that sits on the opposite side of the traffic light controller's interface. It consumes the five `colors` light outputs and produces the five traffic sensor inputs. Per lane, it holds a car queue: cars arrive on stimulus pulses and leave while that lane's light is green. It also runs sticky safety and liveness monitors for conflicting greens, illegal color sequences, starvation and queue overflow. It is a synthesizable checker/stimulus block, used in the controller testbench and on the board demo.

---
 rtl/intersection_model_if.sv | 28 ++
 rtl/intersection_model.sv | 149 ++++++++++++++
 tb/tb_intersection_model.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/intersection_model_if.sv
// Lane-side signals of the intersection traffic model: arrival stimulus in,
// sensors, queue occupancy and sticky monitor flags out.
interface intersection_if;
    logic [4:0]  arrive;
    logic        e_str_sensor;
    logic        w_str_sensor;
    logic        e_left_sensor;
    logic        w_left_sensor;
    logic        ns_sensor;
    logic [19:0] q_count;
    logic [15:0] departed_total;
    logic        conflict;
    logic [4:0]  seq_err;
    logic [4:0]  starve;
    logic [4:0]  overflow;

    modport master (
        output arrive,
        input  e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
        input  q_count, departed_total, conflict, seq_err, starve, overflow
    );

    modport slave (
        input  arrive,
        output e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
        output q_count, departed_total, conflict, seq_err, starve, overflow
    );
endinterface

// File: rtl/intersection_model.sv
// Closed-loop intersection: per-lane car queues driven by the controller's
// lights, plus sticky conflict, sequence, starvation and overflow monitors.
package light_package;
    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } colors;
endpackage

module intersection_model
    import light_package::*;
#(
    parameter int QMAX         = 15,
    parameter int STARVE_LIMIT = 40
) (
    input  logic   clk,
    input  logic   reset,
    input  colors  e_str_light,
    input  colors  w_str_light,
    input  colors  e_left_light,
    input  colors  w_left_light,
    input  colors  ns_light,
    intersection_if.slave bus
);

    localparam logic [3:0] QMAX_C  = 4'(QMAX);
    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    colors            light [5];
    logic [4:0]       non_red;
    logic             conflict_hit;

    logic [4:0][3:0]  count_q, count_d;
    logic [4:0][7:0]  wait_q, wait_d;
    colors            prev_q [5];
    colors            prev_d [5];
    logic [15:0]      departed_q, departed_d;
    logic             conflict_q, conflict_d;
    logic [4:0]       seq_err_q, seq_err_d;
    logic [4:0]       starve_q, starve_d;
    logic [4:0]       overflow_q, overflow_d;

    logic [4:0]       dep;
    logic [4:0]       acc;
    logic [2:0]       dep_sum;

    assign light[0] = e_str_light;
    assign light[1] = w_str_light;
    assign light[2] = e_left_light;
    assign light[3] = w_left_light;
    assign light[4] = ns_light;

    always_comb begin
        non_red = '0;
        for (int i = 0; i < 5; i++) begin
            non_red[i] = (light[i] != RED);
        end
    end

    // Only {e_str,w_str}, {e_str,e_left}, {w_str,w_left}, {e_left,w_left} may
    // share non-red; ns conflicts with everyone.
    assign conflict_hit = (non_red[4] && (|non_red[3:0]))
                        || (non_red[0] && non_red[3])
                        || (non_red[1] && non_red[2]);

    always_comb begin
        count_d    = count_q;
        wait_d     = wait_q;
        departed_d = departed_q;
        conflict_d = conflict_q | conflict_hit;
        seq_err_d  = seq_err_q;
        starve_d   = starve_q;
        overflow_d = overflow_q;
        dep        = '0;
        acc        = '0;
        dep_sum    = '0;
        for (int i = 0; i < 5; i++) begin
            prev_d[i] = light[i];
        end

        for (int i = 0; i < 5; i++) begin
            dep[i] = (light[i] == GREEN) && (count_q[i] != 4'd0);
            // A departing car frees a slot, so a full lane still accepts.
            acc[i] = bus.arrive[i] && ((count_q[i] < QMAX_C) || dep[i]);
            count_d[i] = count_q[i] + {3'b000, acc[i]} - {3'b000, dep[i]};
            if (bus.arrive[i] && !acc[i]) begin
                overflow_d[i] = 1'b1;
            end

            if ((light[i] == RED) && (count_q[i] != 4'd0)) begin
                wait_d[i] = (wait_q[i] == 8'hFF) ? wait_q[i] : wait_q[i] + 8'd1;
            end else begin
                wait_d[i] = 8'd0;
            end
            if (wait_d[i] > LIMIT_C) begin
                starve_d[i] = 1'b1;
            end

            if (((prev_q[i] == GREEN) && (light[i] == RED))
                || ((prev_q[i] == RED) && (light[i] == YELLOW))) begin
                seq_err_d[i] = 1'b1;
            end

            dep_sum = dep_sum + {2'b00, dep[i]};
        end

        departed_d = departed_q + {13'd0, dep_sum};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            wait_q     <= '0;
            departed_q <= '0;
            conflict_q <= 1'b0;
            seq_err_q  <= '0;
            starve_q   <= '0;
            overflow_q <= '0;
            for (int i = 0; i < 5; i++) begin
                prev_q[i] <= RED;
            end
        end else begin
            count_q    <= count_d;
            wait_q     <= wait_d;
            departed_q <= departed_d;
            conflict_q <= conflict_d;
            seq_err_q  <= seq_err_d;
            starve_q   <= starve_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < 5; i++) begin
                prev_q[i] <= prev_d[i];
            end
        end
    end

    assign bus.q_count        = count_q;
    assign bus.e_str_sensor   = (count_q[0] != 4'd0);
    assign bus.w_str_sensor   = (count_q[1] != 4'd0);
    assign bus.e_left_sensor  = (count_q[2] != 4'd0);
    assign bus.w_left_sensor  = (count_q[3] != 4'd0);
    assign bus.ns_sensor      = (count_q[4] != 4'd0);
    assign bus.departed_total = departed_q;
    assign bus.conflict       = conflict_q;
    assign bus.seq_err        = seq_err_q;
    assign bus.starve         = starve_q;
    assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_intersection_model.sv
// Directed and randomized bench for intersection_model, compared every cycle
// against a lane-by-lane behavioural model of the traffic rules.
module tb_intersection_model;
    import light_package::*;

    localparam int QMAX  = 15;
    localparam int LIMIT = 40;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    colors lt [5];

    intersection_if bus();

    intersection_model #(.QMAX(QMAX), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .e_str_light  (lt[0]),
        .w_str_light  (lt[1]),
        .e_left_light (lt[2]),
        .w_left_light (lt[3]),
        .ns_light     (lt[4]),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int    m_cnt  [5];
    int    m_wait [5];
    int    m_departed;
    bit    m_conf;
    bit    m_seq    [5];
    bit    m_starve [5];
    bit    m_ovf    [5];
    colors m_prev   [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit allowed_pair(input int a, input int b);
        return (a == 0 && b == 1) || (a == 0 && b == 2) || (a == 1 && b == 3) || (a == 2 && b == 3);
    endfunction

    task automatic model_edge(input bit rst, input bit [4:0] arr);
        if (rst) begin
            m_departed = 0;
            m_conf = 0;
            for (int i = 0; i < 5; i++) begin
                m_cnt[i] = 0; m_wait[i] = 0; m_seq[i] = 0;
                m_starve[i] = 0; m_ovf[i] = 0; m_prev[i] = RED;
            end
            return;
        end
        for (int i = 0; i < 5; i++) begin
            for (int j = i + 1; j < 5; j++) begin
                if (lt[i] != RED && lt[j] != RED && !allowed_pair(i, j)) m_conf = 1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            int  old = m_cnt[i];
            bit  leaving = (lt[i] == GREEN) && (old > 0);
            if (arr[i]) begin
                if (old < QMAX || leaving) m_cnt[i] = m_cnt[i] + 1;
                else m_ovf[i] = 1;
            end
            if (leaving) begin
                m_cnt[i] = m_cnt[i] - 1;
                m_departed = (m_departed + 1) % 65536;
            end
            if (lt[i] == RED && old > 0) m_wait[i] = (m_wait[i] >= 255) ? 255 : m_wait[i] + 1;
            else m_wait[i] = 0;
            if (m_wait[i] > LIMIT) m_starve[i] = 1;
            if ((m_prev[i] == GREEN && lt[i] == RED) || (m_prev[i] == RED && lt[i] == YELLOW))
                m_seq[i] = 1;
            m_prev[i] = lt[i];
        end
    endtask

    task automatic check_all();
        logic [19:0] q;
        logic [4:0]  sens, seq, stv, ovf;
        for (int i = 0; i < 5; i++) begin
            q[4*i +: 4] = 4'(m_cnt[i]);
            sens[i] = (m_cnt[i] != 0);
            seq[i]  = m_seq[i];
            stv[i]  = m_starve[i];
            ovf[i]  = m_ovf[i];
        end
        chk("q_count", 32'(bus.q_count), 32'(q));
        chk("sensors", 32'({bus.ns_sensor, bus.w_left_sensor, bus.e_left_sensor,
                            bus.w_str_sensor, bus.e_str_sensor}), 32'(sens));
        chk("departed_total", 32'(bus.departed_total), 32'(m_departed));
        chk("conflict", 32'(bus.conflict), 32'(m_conf));
        chk("seq_err", 32'(bus.seq_err), 32'(seq));
        chk("starve", 32'(bus.starve), 32'(stv));
        chk("overflow", 32'(bus.overflow), 32'(ovf));
    endtask

    task automatic set_lights(input colors c0, input colors c1, input colors c2,
                              input colors c3, input colors c4);
        lt[0] = c0; lt[1] = c1; lt[2] = c2; lt[3] = c3; lt[4] = c4;
    endtask

    task automatic step(input bit rst, input bit [4:0] arr, input int n);
        for (int k = 0; k < n; k++) begin
            reset = rst;
            bus.arrive = arr;
            @(posedge clk);
            model_edge(rst, arr);
            #1;
            check_all();
        end
    endtask

    initial begin
        set_lights(RED, RED, RED, RED, RED);
        bus.arrive = '0;

        // Reset state
        step(1, 5'b00000, 1);
        chk("rst_q_count", 32'(bus.q_count), 0);
        chk("rst_flags", 32'({bus.conflict, bus.seq_err, bus.starve, bus.overflow}), 0);

        // Three arrivals on e_str, then drain on green
        step(0, 5'b00001, 3);
        chk("tp1_count", 32'(bus.q_count[3:0]), 3);
        chk("tp1_sensor", 32'(bus.e_str_sensor), 1);
        set_lights(GREEN, RED, RED, RED, RED);
        step(0, 5'b00000, 3);
        chk("tp1_drained", 32'(bus.q_count[3:0]), 0);
        chk("tp1_sensor_off", 32'(bus.e_str_sensor), 0);
        chk("tp1_departed", 32'(bus.departed_total), 3);
        set_lights(YELLOW, RED, RED, RED, RED);
        step(0, 5'b00000, 1);
        set_lights(RED, RED, RED, RED, RED);
        step(0, 5'b00000, 1);

        // Fill ns to capacity, overflow, then arrive while departing at full
        step(0, 5'b10000, 15);
        chk("tp2_full", 32'(bus.q_count[19:16]), 15);
        chk("tp2_no_ovf_yet", 32'(bus.overflow[4]), 0);
        step(0, 5'b10000, 1);
        chk("tp2_full_hold", 32'(bus.q_count[19:16]), 15);
        chk("tp2_ovf", 32'(bus.overflow[4]), 1);
        set_lights(RED, RED, RED, RED, GREEN);
        step(0, 5'b10000, 3);
        chk("tp2_still_full", 32'(bus.q_count[19:16]), 15);
        chk("tp2_departed", 32'(bus.departed_total), 6);
        set_lights(RED, RED, RED, RED, YELLOW);
        step(0, 5'b00000, 1);
        set_lights(RED, RED, RED, RED, RED);
        step(0, 5'b00000, 1);

        // Compatible pair stays clean, ns with e_left conflicts and sticks
        set_lights(GREEN, GREEN, RED, RED, RED);
        step(0, 5'b00000, 1);
        set_lights(GREEN, YELLOW, RED, RED, RED);
        step(0, 5'b00000, 1);
        chk("tp3_no_conflict", 32'(bus.conflict), 0);
        set_lights(YELLOW, RED, GREEN, RED, RED);
        step(0, 5'b00000, 1);
        set_lights(RED, RED, YELLOW, RED, GREEN);
        step(0, 5'b00000, 1);
        chk("tp3_conflict", 32'(bus.conflict), 1);
        set_lights(RED, RED, RED, RED, YELLOW);
        step(0, 5'b00000, 1);
        set_lights(RED, RED, RED, RED, RED);
        step(0, 5'b00000, 2);
        chk("tp3_conflict_sticky", 32'(bus.conflict), 1);

        // Missing yellow on w_left, clean cycle on e_left
        set_lights(RED, RED, GREEN, GREEN, RED);
        step(0, 5'b00000, 1);
        set_lights(RED, RED, YELLOW, RED, RED);
        step(0, 5'b00000, 1);
        chk("tp4_seq_wleft", 32'(bus.seq_err[3]), 1);
        step(0, 5'b00000, 1);
        set_lights(RED, RED, RED, RED, RED);
        step(0, 5'b00000, 1);
        chk("tp4_seq_eleft", 32'(bus.seq_err[2]), 0);

        // Starvation on w_str at exactly LIMIT+1 waiting cycles
        step(1, 5'b00000, 1);
        step(0, 5'b00010, 1);
        step(0, 5'b00000, LIMIT);
        chk("tp5_not_starved", 32'(bus.starve[1]), 0);
        step(0, 5'b00000, 1);
        chk("tp5_starved", 32'(bus.starve[1]), 1);

        // Control: a green pulse at cycle 30 restarts the wait
        step(1, 5'b00000, 1);
        step(0, 5'b00010, 2);
        step(0, 5'b00000, 29);
        set_lights(RED, GREEN, RED, RED, RED);
        step(0, 5'b00000, 1);
        set_lights(RED, YELLOW, RED, RED, RED);
        step(0, 5'b00000, 1);
        set_lights(RED, RED, RED, RED, RED);
        step(0, 5'b00000, 35);
        chk("tp5_ctrl_no_starve", 32'(bus.starve[1]), 0);
        chk("tp5_ctrl_count", 32'(bus.q_count[7:4]), 1);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            bit [4:0] arr;
            bit       rst;
            if (c % 4 == 0) begin
                for (int i = 0; i < 5; i++) begin
                    int r = $urandom_range(0, 9);
                    lt[i] = (r < 6) ? RED : ((r < 8) ? GREEN : YELLOW);
                end
            end
            arr = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            rst = ($urandom_range(0, 99) == 0);
            step(rst, arr, 1);
        end

        // Mid-run reset with busy queues and set flags; reset-cycle arrivals ignored
        set_lights(RED, RED, RED, RED, GREEN);
        step(0, 5'b11111, 2);
        set_lights(RED, RED, RED, RED, RED);
        step(0, 5'b11111, 1);
        step(1, 5'b11111, 1);
        chk("tp6_q_zero", 32'(bus.q_count), 0);
        chk("tp6_flags_zero", 32'({bus.conflict, bus.seq_err, bus.starve, bus.overflow}), 0);
        chk("tp6_departed_zero", 32'(bus.departed_total), 0);
        step(0, 5'b00000, 1);
        chk("tp6_after_reset", 32'(bus.q_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
